circle_map_gen: RTL and testbench
=================================

CIRCLE_MAP_GEN -- requirements
Module: circle_map_gen

Interface
REQ-001 SHALL have parameter GRID, default 8, meaning grid side length in cells (2..15).
REQ-002 SHALL have parameter CW, default 4, meaning width of each coordinate and radius field.
REQ-003 SHALL have parameter NC, default 2, meaning number of circles combined per map (1..4).
REQ-004 SHALL have port clk  input  1  meaning the rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port start  input  1  meaning a one-cycle request to begin map generation.
REQ-007 SHALL have port cx  input  NC*CW  meaning circle centre x values, circle k at [k*CW +: CW].
REQ-008 SHALL have port cy  input  NC*CW  meaning circle centre y values, packed as for cx.
REQ-009 SHALL have port cr  input  NC*CW  meaning circle radii, packed as for cx.
REQ-010 SHALL have port mode  input  2  meaning the combine mode: 00 union, 01 intersection, 10 xor, 11 union.
REQ-011 SHALL have port map  output  GRID*GRID  meaning the cell bitmap; cell (x,y) is at bit (y-1)*GRID+(x-1).
REQ-012 SHALL have port count  output  $clog2(GRID*GRID+1)  meaning the number of set map bits.
REQ-013 SHALL have port busy  output  1  meaning generation is in progress.
REQ-014 SHALL have port done  output  1  meaning a one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and FIN.
REQ-016 SHALL, in IDLE with start=1, latch cx/cy/cr/mode, clear map and count, set x=y=1 and go to CALC at that edge.
REQ-017 SHALL ignore start while in CALC or FIN; latched operands SHALL NOT change mid-run.
REQ-018 SHALL, in CALC, evaluate exactly one cell per cycle in row-major order: x runs 1..GRID, then y increments and x returns to 1.
REQ-019 SHALL set a cell's per-circle hit iff (x-cx)^2+(y-cy)^2 <= cr^2, computed signed/unsigned-safe in at least 2*CW+2 bits with no truncation.
REQ-020 SHALL treat r=0 as hitting only the centre cell; centres outside 1..GRID SHALL be legal (clipped circle).
REQ-021 SHALL combine the NC hits per cell according to mode: OR, AND, or parity (xor).
REQ-022 SHALL write the combined bit to map, and increment count when the bit is 1, in the same cycle the cell is evaluated.
REQ-023 SHALL move from CALC to FIN after cell (GRID,GRID) is evaluated; FIN SHALL assert done for one cycle and return to IDLE.
REQ-024 SHALL produce done exactly GRID*GRID+1 cycles after the start-accepting edge (65 cycles for the defaults).
REQ-025 SHALL drive busy=1 in CALC and FIN, and 0 in IDLE.
REQ-026 SHALL hold map and count stable from done until the next accepted start.
REQ-027 SHALL accept a start arriving in the cycle after done (back-to-back operation).

Reset
REQ-028 SHALL, while reset=0, asynchronously force state IDLE, map=0, count=0, busy=0 and done=0, and clear internal x/y/operand registers.
REQ-029 SHALL, when reset asserts mid-CALC, abort the run with no done pulse, discard the partial map, and return to IDLE; the first edge after release SHALL accept start.

Verification
REQ-030 SHALL be verified with GRID=8, NC=1, circle (1,1,1), union -> map bits 0, 1 and 8 set only, count=3, done at cycle 65.
REQ-031 SHALL be verified with NC=2, circles (1,1,1) and (8,8,1), intersection -> map=0, count=0; the same circles with union -> count=6.
REQ-032 SHALL be verified with NC=1, circle (1,1,12) -> map all ones, count=64; circle (4,4,0) -> only bit 27 set, count=1.
REQ-033 SHALL be verified with NC=2, two identical circles (4,4,3), xor -> map=0; the same circles with union -> map equal to the single-circle result.
REQ-034 SHALL be verified by asserting reset at cycle 30 of a run -> done never pulses, map=0, busy=0; a new start then completes normally.
REQ-035 SHALL be verified by applying start during busy -> it is ignored and operands are unchanged; randomised runs SHALL match a reference model cell-by-cell with zero errors.

Source files
------------

// File: rtl/circle_map_gen.sv
`default_nettype none
// ============================================================================
// Module   : circle_map_gen
// Purpose  : Rasterises NC circles onto a GRID x GRID bitmap, one cell per
//            clock, merging per-circle hits by union, intersection or xor.
// Revision : 1.0
// ============================================================================
module circle_map_gen #(
  parameter int GRID = 8,
  parameter int CW   = 4,
  parameter int NC   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NC*CW-1:0]               cx,
  input  logic [NC*CW-1:0]               cy,
  input  logic [NC*CW-1:0]               cr,
  input  logic [1:0]                     mode,
  output logic [GRID*GRID-1:0]           map,
  output logic [$clog2(GRID*GRID+1)-1:0] count,
  output logic                           busy,
  output logic                           done
);

  localparam int c_NCELL = GRID * GRID;
  localparam int c_CNTW  = $clog2(c_NCELL + 1);
  localparam int c_IW    = $clog2(c_NCELL);
  localparam int c_XW    = $clog2(GRID + 1);
  localparam int c_MW    = (CW > c_XW) ? CW : c_XW;
  // Headroom so squared signed distances of any legal centre never wrap.
  localparam int c_DW    = 2 * c_MW + 4;

  localparam logic [c_XW-1:0] c_GRID_X = c_XW'(GRID);
  localparam logic [c_XW-1:0] c_ONE_X  = c_XW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [NC*CW-1:0]     r_cx;
  logic [NC*CW-1:0]     r_cy;
  logic [NC*CW-1:0]     r_cr;
  logic [1:0]           r_mode;
  logic [c_XW-1:0]      r_x;
  logic [c_XW-1:0]      r_y;
  logic [c_IW-1:0]      r_idx;
  logic [c_NCELL-1:0]   r_map;
  logic [c_CNTW-1:0]    r_count;

  logic [NC-1:0]        w_hit;
  logic                 w_bit;
  logic                 w_last;

  assign w_last = (r_x == c_GRID_X) && (r_y == c_GRID_X);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  genvar k;
  generate
    for (k = 0; k < NC; k++) begin : g_circle
      logic signed [c_DW-1:0] w_dx;
      logic signed [c_DW-1:0] w_dy;
      logic signed [c_DW-1:0] w_d2;
      logic signed [c_DW-1:0] w_r2;

      assign w_dx     = c_DW'(r_x) - c_DW'(r_cx[k*CW +: CW]);
      assign w_dy     = c_DW'(r_y) - c_DW'(r_cy[k*CW +: CW]);
      assign w_d2     = (w_dx * w_dx) + (w_dy * w_dy);
      assign w_r2     = c_DW'(r_cr[k*CW +: CW]) * c_DW'(r_cr[k*CW +: CW]);
      assign w_hit[k] = (w_d2 <= w_r2);
    end
  endgenerate

  always_comb begin
    w_bit = 1'b0;
    case (r_mode)
      2'b01:   w_bit = &w_hit;
      2'b10:   w_bit = ^w_hit;
      default: w_bit = |w_hit;
    endcase
  end

  // r_idx tracks (y-1)*GRID+(x-1) incrementally, avoiding a multiplier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_cr    <= '0;
      r_mode  <= 2'b00;
      r_x     <= '0;
      r_y     <= '0;
      r_idx   <= '0;
      r_map   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cx    <= cx;
            r_cy    <= cy;
            r_cr    <= cr;
            r_mode  <= mode;
            r_x     <= c_ONE_X;
            r_y     <= c_ONE_X;
            r_idx   <= '0;
            r_map   <= '0;
            r_count <= '0;
          end
        end
        S_CALC: begin
          r_map[r_idx] <= w_bit;
          if (w_bit) begin
            r_count <= r_count + c_CNTW'(1);
          end
          if (!w_last) begin
            r_idx <= r_idx + c_IW'(1);
            if (r_x == c_GRID_X) begin
              r_x <= c_ONE_X;
              r_y <= r_y + c_ONE_X;
            end else begin
              r_x <= r_x + c_ONE_X;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign map   = r_map;
  assign count = r_count;
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_circle_map_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_circle_map_gen
// Purpose  : Directed and randomised checks of circle_map_gen (GRID=8, CW=4)
//            using one NC=1 and one NC=2 instance on a shared clock/reset.
// Revision : 1.0
// ============================================================================
module tb_circle_map_gen;

  localparam logic [63:0] c_C1    = 64'h0000_0000_0000_0103;
  localparam logic [63:0] c_C2U   = 64'hC080_0000_0000_0103;
  localparam logic [63:0] c_ALL   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_DOT   = 64'h0000_0000_0800_0000;
  localparam logic [63:0] c_CIRC  = 64'h0008_3E3E_7F3E_3E08;

  logic        clk;
  logic        reset;
  logic        start1, start2;
  logic [3:0]  cx1, cy1, cr1;
  logic [7:0]  cx2, cy2, cr2;
  logic [1:0]  mode1, mode2;
  logic [63:0] map1, map2;
  logic [6:0]  count1, count2;
  logic        busy1, busy2, done1, done2;

  int n_cmp  = 0;
  int n_fail = 0;

  circle_map_gen #(.GRID(8), .CW(4), .NC(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .cx(cx1), .cy(cy1), .cr(cr1),
    .mode(mode1), .map(map1), .count(count1), .busy(busy1), .done(done1)
  );

  circle_map_gen #(.GRID(8), .CW(4), .NC(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .cx(cx2), .cy(cy2), .cr(cr2),
    .mode(mode2), .map(map2), .count(count2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 1) ? busy1 : busy2;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 1) ? done1 : done2;
  endfunction

  task automatic drive(input int sel, input logic [7:0] ax, input logic [7:0] ay,
                       input logic [7:0] ar, input logic [1:0] md, input logic st);
    if (sel == 1) begin
      cx1 = ax[3:0]; cy1 = ay[3:0]; cr1 = ar[3:0]; mode1 = md; start1 = st;
    end else begin
      cx2 = ax; cy2 = ay; cr2 = ar; mode2 = md; start2 = st;
    end
  endtask

  task automatic set_start(input int sel, input logic st);
    if (sel == 1) start1 = st;
    else          start2 = st;
  endtask

  // Called at a negedge; returns at the negedge of the cycle after done.
  // spur>0 pulses start with different operands at that cycle of the run.
  task automatic run(input int sel, input logic [7:0] ax, input logic [7:0] ay,
                     input logic [7:0] ar, input logic [1:0] md, input int spur);
    int lat;
    lat = 0;
    drive(sel, ax, ay, ar, md, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == spur) drive(sel, 8'h11, 8'h11, 8'hCC, 2'b10, 1'b1);
      else           set_start(sel, 1'b0);
      if (k == 1) check("busy_run", 64'(busy_of(sel)), 64'd1);
      if (done_of(sel)) begin
        lat = k + 1;
        break;
      end
    end
    check("done_cycle", 64'(lat), 64'd65);
    check("busy_fin", 64'(busy_of(sel)), 64'd1);
    @(negedge clk);
    set_start(sel, 1'b0);
    check("done_pulse", 64'(done_of(sel)), 64'd0);
    check("busy_idle", 64'(busy_of(sel)), 64'd0);
  endtask

  function automatic logic [63:0] ref_map(input logic [7:0] ax, input logic [7:0] ay,
                                          input logic [7:0] ar, input logic [1:0] md,
                                          input int nc);
    logic [63:0] m;
    m = '0;
    for (int y = 1; y <= 8; y++) begin
      for (int x = 1; x <= 8; x++) begin
        logic acc;
        acc = (md == 2'b01);
        for (int c = 0; c < nc; c++) begin
          int dx, dy, r;
          logic h;
          dx = x - int'(ax[c*4 +: 4]);
          dy = y - int'(ay[c*4 +: 4]);
          r  = int'(ar[c*4 +: 4]);
          h  = (dx * dx + dy * dy) <= (r * r);
          case (md)
            2'b01:   acc = acc & h;
            2'b10:   acc = acc ^ h;
            default: acc = acc | h;
          endcase
        end
        m[(y - 1) * 8 + (x - 1)] = acc;
      end
    end
    return m;
  endfunction

  initial begin
    logic [7:0]  rx, ry, rr;
    logic [1:0]  rm;
    logic [63:0] exp_m, got_m;
    logic        seen_done;

    reset = 1'b0;
    drive(1, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
    drive(2, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_map", map1, 64'd0);
    check("rst_count", 64'(count1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done2), 64'd0);
    reset = 1'b1;

    run(1, 8'h01, 8'h01, 8'h01, 2'b00, 0);
    check("c111_map", map1, c_C1);
    check("c111_count", 64'(count1), 64'd3);
    repeat (3) @(negedge clk);
    check("hold_map", map1, c_C1);
    check("hold_count", 64'(count1), 64'd3);

    // Circle 0 = (1,1,1), circle 1 = (8,8,1); runs are issued back-to-back.
    run(2, 8'h81, 8'h81, 8'h11, 2'b01, 0);
    check("and_map", map2, 64'd0);
    check("and_count", 64'(count2), 64'd0);
    run(2, 8'h81, 8'h81, 8'h11, 2'b00, 0);
    check("or_map", map2, c_C2U);
    check("or_count", 64'(count2), 64'd6);
    run(2, 8'h81, 8'h81, 8'h11, 2'b11, 0);
    check("or11_map", map2, c_C2U);
    check("or11_count", 64'(count2), 64'd6);

    run(1, 8'h01, 8'h01, 8'h0C, 2'b00, 0);
    check("big_map", map1, c_ALL);
    check("big_count", 64'(count1), 64'd64);
    run(1, 8'h04, 8'h04, 8'h00, 2'b00, 0);
    check("dot_map", map1, c_DOT);
    check("dot_count", 64'(count1), 64'd1);

    run(2, 8'h44, 8'h44, 8'h33, 2'b10, 0);
    check("xor_map", map2, 64'd0);
    check("xor_count", 64'(count2), 64'd0);
    run(2, 8'h44, 8'h44, 8'h33, 2'b00, 0);
    check("dup_or_map", map2, c_CIRC);
    check("dup_or_count", 64'(count2), 64'd29);
    run(1, 8'h04, 8'h04, 8'h03, 2'b00, 0);
    check("single_map", map1, c_CIRC);
    check("single_count", 64'(count1), 64'd29);

    // Abort a run with reset at cycle 30.
    drive(1, 8'h01, 8'h01, 8'h0C, 2'b00, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(1, 1'b0);
    repeat (29) @(negedge clk);
    check("mid_count", 64'(count1), 64'd29);
    check("mid_busy", 64'(busy1), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_map", map1, 64'd0);
    check("abort_count", 64'(count1), 64'd0);
    check("abort_busy", 64'(busy1), 64'd0);
    check("abort_done", 64'(done1), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_done = seen_done | done1;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_idle_map", map1, 64'd0);
    check("abort_idle_busy", 64'(busy1), 64'd0);
    run(1, 8'h04, 8'h04, 8'h00, 2'b00, 0);
    check("post_abort_map", map1, c_DOT);

    // Start on the very first edge after reset release.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run(1, 8'h01, 8'h01, 8'h01, 2'b00, 0);
    check("rel_start_map", map1, c_C1);
    check("rel_start_count", 64'(count1), 64'd3);

    // Start pulses while busy (mid-CALC, then in FIN) must be ignored.
    run(1, 8'h04, 8'h04, 8'h00, 2'b00, 10);
    check("spur_calc_map", map1, c_DOT);
    check("spur_calc_count", 64'(count1), 64'd1);
    run(1, 8'h01, 8'h01, 8'h01, 2'b00, 64);
    check("spur_fin_map", map1, c_C1);
    check("spur_fin_count", 64'(count1), 64'd3);

    for (int i = 0; i < 6; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rr = 8'($urandom_range(0, 255));
      rm = 2'($urandom_range(0, 3));
      exp_m = ref_map(rx, ry, rr, rm, 2);
      run(2, rx, ry, rr, rm, 0);
      got_m = map2;
      for (int c = 0; c < 64; c++) begin
        check("rnd_cell", 64'(got_m[c]), 64'(exp_m[c]));
      end
      check("rnd_count", 64'(count2), 64'($countones(exp_m)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
